// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - iterative shift sequencer (SLL/SRL/SRA/ROTR) reusing a 1-bit stage; optional 4-bit stage under SHIFT_SEQ_FAST_EN
module shift_seq_ctrl #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic               flush_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [DATA_W-1:0]  data_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [DATA_W-1:0]  work_q, work_d;
   logic [DATA_W-1:0]  data_q, data_d;

   // Single-position shift stage; anything not SLL/SRL/SRA is rotate-right.
   function automatic logic [DATA_W-1:0] shift1(input logic [1:0] op, input logic [DATA_W-1:0] w);
      case (op)
         OP_SLL:  shift1 = {w[DATA_W-2:0], 1'b0};
         OP_SRL:  shift1 = {1'b0, w[DATA_W-1:1]};
         OP_SRA:  shift1 = {w[DATA_W-1], w[DATA_W-1:1]};
         default: shift1 = {w[0], w[DATA_W-1:1]};
      endcase
   endfunction

`ifdef SHIFT_SEQ_FAST_EN
   // Four-position stage, same fill/rotate rules as the 1-bit stage.
   function automatic logic [DATA_W-1:0] shift4(input logic [1:0] op, input logic [DATA_W-1:0] w);
      case (op)
         OP_SLL:  shift4 = {w[DATA_W-5:0], 4'b0000};
         OP_SRL:  shift4 = {4'b0000, w[DATA_W-1:4]};
         OP_SRA:  shift4 = {{4{w[DATA_W-1]}}, w[DATA_W-1:4]};
         default: shift4 = {w[3:0], w[DATA_W-1:4]};
      endcase
   endfunction
`endif

   // Next-state logic: accept in IDLE/DONE, iterate in SHIFT, abort on flush.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      work_d  = work_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               op_d    = op_i;
               work_d  = data_i;
               count_d = shamt_i;
               if (shamt_i != '0) begin
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_DONE;
                  data_d  = data_i;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (flush_i) begin
               // Abandon the operation; the previous result stays visible.
               state_d = S_IDLE;
            end else begin
`ifdef SHIFT_SEQ_FAST_EN
               if (count_q >= SHAMT_W'(4)) begin
                  work_d  = shift4(op_q, work_q);
                  count_d = count_q - SHAMT_W'(4);
               end else begin
                  work_d  = shift1(op_q, work_q);
                  count_d = count_q - SHAMT_W'(1);
               end
`else
               work_d  = shift1(op_q, work_q);
               count_d = count_q - SHAMT_W'(1);
`endif
               if (count_d == '0) begin
                  state_d = S_DONE;
                  data_d  = work_d;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         op_q    <= OP_SLL;
         count_q <= '0;
         work_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         work_q  <= work_d;
         data_q  <= data_d;
      end
   end

   assign busy_o = (state_q == S_SHIFT);
   assign done_o = (state_q == S_DONE);
   assign data_o = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [4:0]  shamt_i = 5'd0;
   logic [31:0] data_i = 32'h0;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] data_o;

   int n_checks = 0;
   int n_fails  = 0;

   shift_seq_ctrl #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .op_i    (op_i),
      .shamt_i (shamt_i),
      .data_i  (data_i),
      .flush_i (flush_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .data_o  (data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Number of SHIFT cycles expected for a given amount.
   function automatic int exp_busy(input logic [4:0] sh);
`ifdef SHIFT_SEQ_FAST_EN
      exp_busy = int'(sh) / 4 + int'(sh) % 4;
`else
      exp_busy = int'(sh);
`endif
   endfunction

   // Issue one op in the current cycle and return in its DONE cycle.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] sh,
                         input logic [31:0] din, input logic [31:0] exp);
      int nb;
      nb = 0;
      op_i = op; shamt_i = sh; data_i = din; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      while (busy_o === 1'b1 && nb < 64) begin
         nb++;
         tick();
      end
      chk({tag, "_busy_cycles"}, nb, exp_busy(sh));
      chk({tag, "_done"}, {31'b0, done_o}, 32'd1);
      chk({tag, "_data"}, data_o, exp);
   endtask

   initial begin
      int nb;
      // Reset
      rst_i = 1'b0;
      tick(); tick();
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_data", data_o, 32'h0);
      rst_i = 1'b1;
      tick();

      // SRA with sign replication
      run_op("sra4", 2'b10, 5'd4, 32'h8000_0000, 32'hF800_0000);
      tick();
      chk("sra4_pulse_end", {31'b0, done_o}, 32'd0);
      chk("sra4_hold", data_o, 32'hF800_0000);

      // ROTR then back-to-back SLL issued in the DONE cycle
      run_op("rotr1", 2'b11, 5'd1, 32'h0000_0001, 32'h8000_0000);
      run_op("sll31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
      tick();
      chk("sll31_idle", {30'b0, busy_o, done_o}, 32'd0);

      // Zero shift amount goes straight to DONE
      run_op("srl0", 2'b01, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      tick();

      // Start during SHIFT is ignored
      op_i = 2'b00; shamt_i = 5'd8; data_i = 32'h0000_000F; start_i = 1'b1;
      tick();
      nb = 0;
      if (busy_o === 1'b1) nb++;
      op_i = 2'b01; shamt_i = 5'd1; data_i = 32'hFFFF_FFFF; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      while (busy_o === 1'b1 && nb < 64) begin
         nb++;
         tick();
      end
      chk("ign_busy_cycles", nb, exp_busy(5'd8));
      chk("ign_done", {31'b0, done_o}, 32'd1);
      chk("ign_data", data_o, 32'h0000_0F00);
      tick();
      chk("ign_no_second", {30'b0, busy_o, done_o}, 32'd0);
      chk("ign_hold", data_o, 32'h0000_0F00);

      // Flush in SHIFT aborts and preserves the previous result
      run_op("sll2", 2'b00, 5'd2, 32'h0000_0001, 32'h0000_0004);
      tick();
      op_i = 2'b01; shamt_i = 5'd10; data_i = 32'hFFFF_FFFF; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick();
      chk("fl_busy_before", {31'b0, busy_o}, 32'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("fl_busy", {31'b0, busy_o}, 32'd0);
      chk("fl_done", {31'b0, done_o}, 32'd0);
      chk("fl_data", data_o, 32'h0000_0004);
      tick();
      chk("fl_no_done_later", {31'b0, done_o}, 32'd0);

      // Flush together with start in IDLE: start wins
      flush_i = 1'b1;
      run_op("fl_start", 2'b00, 5'd0, 32'h1234_5678, 32'h1234_5678);
      flush_i = 1'b0;
      tick();

      // Reset mid-operation
      op_i = 2'b00; shamt_i = 5'd20; data_i = 32'h0000_0001; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      chk("mr_busy_before", {31'b0, busy_o}, 32'd1);
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      chk("mr_busy", {31'b0, busy_o}, 32'd0);
      chk("mr_done", {31'b0, done_o}, 32'd0);
      chk("mr_data", data_o, 32'h0);
      tick();
      run_op("post_rst", 2'b10, 5'd4, 32'hF000_0000, 32'hFF00_0000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle shift sequencer for the MIPS datapath's shift instructions (SLL/SRL/SRA and rotate-right).
- Owns one 1-bit shift stage and reuses it iteratively under a small FSM, instead of a full 32-bit barrel shifter.
- Sits beside the ALU. The main control unit issues a start pulse and stalls the pipeline while busy_o is high.
- Result is held on data_o until the next completed operation.

Parameters:
- DATA_W, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W == DATA_W.

Ports:
- clk_i  in  1  system clock, rising-edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  request a shift; sampled on clk_i rising edge.
- op_i  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROTR; captured with start.
- shamt_i  in  SHAMT_W  shift amount; captured with start.
- data_i  in  DATA_W  operand; captured with start.
- flush_i  in  1  abort in-flight operation (pipeline flush).
- busy_o  out  1  high while an operation is in progress (state SHIFT).
- done_o  out  1  one-cycle completion pulse (state DONE).
- data_o  out  DATA_W  last completed result.

Behaviour:
- Reset (rst_i==0 at a rising edge): state=IDLE, busy_o=0, done_o=0, data_o=0, internal count=0, work register=0. Reset overrides every other input, including mid-operation.
- State IDLE:
  - start_i=1 captures op, data and shamt into the work register and count.
  - shamt!=0 → SHIFT. shamt==0 → DONE.
- State SHIFT:
  - Each edge shifts the work register by 1 per op:
    - SLL: zero-fill at LSB.
    - SRL: zero-fill at MSB.
    - SRA: MSB replicated.
    - ROTR: bit0 moves to bit31.
  - count decrements by 1 per edge; when it reaches 0 → DONE.
  - start_i is ignored; no queuing.
- State DONE:
  - done_o=1 for exactly this cycle.
  - data_o loads the work register on the edge that enters DONE and stays stable afterwards.
  - Next edge: start_i=1 is accepted exactly as in IDLE (back-to-back issue); otherwise → IDLE.
- busy_o = (state==SHIFT); done_o = (state==DONE). Both are registered state decodes with no combinational path from inputs.
- Latency, from the edge that samples start to the cycle done_o is high: max(shamt,1) cycles. Example: shamt=5 gives SHIFT for 5 cycles, then done_o in cycle 6.
- flush_i=1 in SHIFT: → IDLE next edge, no done_o, data_o unchanged.
- flush_i in IDLE or DONE: no effect. The DONE pulse still completes.
- flush_i and start_i together in IDLE or DONE: start is accepted.
- Only the low SHAMT_W bits of shamt_i are used; count never underflows.

Optional Feature:
- Macro SHIFT_SEQ_FAST_EN.
- Defined: each SHIFT cycle shifts by 4 when count>=4 (op-specific fill/rotate, count-=4), otherwise by 1.
  - Latency = max(floor(shamt/4) + shamt%4, 1).
- Undefined: 1-bit stage only; no 4-bit stage logic is synthesized.
- Results are identical in both builds.

Test Plan:
- SRA, data=0x80000000, shamt=4 → data_o=0xF8000000, done_o high exactly 4 cycles after start (1 cycle with FAST_EN), busy_o high 4 cycles.
- ROTR, data=0x00000001, shamt=1 → data_o=0x80000000 after 1 cycle. Then SLL, data=0x00000001, shamt=31 issued in the DONE cycle → data_o=0x80000000 after 31 cycles (10 with FAST_EN), no idle gap.
- SRL, data=0xDEADBEEF, shamt=0 → data_o=0xDEADBEEF, done_o 1 cycle after start, busy_o never high.
- SLL, data=0x0000000F, shamt=8; re-assert start_i with shamt=1 during SHIFT → second start ignored, data_o=0x00000F00, single done_o pulse.
- Complete SLL data=0x1 shamt=2 (data_o=0x4). Then start SRL data=0xFFFFFFFF shamt=10 and assert flush_i at cycle 3 → IDLE, no done_o, data_o stays 0x00000004.
- rst_i=0 during SHIFT of SLL shamt=20 → next edge busy_o=0, done_o=0, data_o=0x00000000. A new start after release behaves normally.
